// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - single-clock CPU run controller (IDLE/RUN/PAUSE/STEP/DONE); RUN_CTRL_BP_EN adds the fetch breakpoint
module cpu_run_ctrl #(
    parameter int unsigned DIV       = 25'd16777216,
    parameter int unsigned DB_CYCLES = 20'd500000,
    parameter logic [4:0]  HALT_OP   = 5'b00001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_sw,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  i_addr,
    input  logic [15:0] instruction,
    output logic        cpu_en,
    output logic        cpu_start,
    output logic [2:0]  state,
    output logic [15:0] cycle_cnt
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_STEP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             start_s1, start_s2, start_q;
    logic             run_s1, run_s2;
    logic             step_s1, step_s2;
    logic [DB_W-1:0]  db_cnt;
    logic             db_level, db_level_q;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      cnt_q, cnt_d;
    logic             start_edge, step_evt, halt_hit, bp_hit, tick;
    logic             en_d, set_skip;
    logic             unused_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            {start_s1, start_s2, start_q} <= 3'b000;
            {run_s1, run_s2}              <= 2'b00;
            {step_s1, step_s2}            <= 2'b00;
        end else begin
            {start_s1, start_s2, start_q} <= {start_sw, start_s1, start_s2};
            {run_s1, run_s2}              <= {run_sw, run_s1};
            {step_s1, step_s2}            <= {step_btn, step_s1};
        end
    end

    // Button level flips only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
        end else begin
            db_level_q <= db_level;
            if (step_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= step_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign start_edge   = start_s2 & ~start_q;
    assign step_evt     = db_level & ~db_level_q;
    assign halt_hit     = (instruction[15:11] == HALT_OP);
    assign tick         = (state_q == S_RUN) && (div_cnt == DIV_LAST);
    assign unused_instr = ^instruction[10:0];

`ifdef RUN_CTRL_BP_EN
    logic bp_skip;

    assign bp_hit = bp_en && (i_addr == bp_addr) && !bp_skip;

    // Lets execution step off the breakpoint address it is parked on
    always_ff @(posedge clk) begin
        if (reset) bp_skip <= 1'b0;
        else if (set_skip) bp_skip <= 1'b1;
        else if (en_d) bp_skip <= 1'b0;
    end
`else
    logic unused_bp;

    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_en, bp_addr, i_addr, set_skip};
`endif

    always_comb begin
        state_d  = state_q;
        en_d     = 1'b0;
        set_skip = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = run_s2 ? S_RUN : S_PAUSE;
            end
            S_RUN: begin
                if (halt_hit) state_d = S_DONE;
                else if (bp_hit || !run_s2) state_d = S_PAUSE;
                else en_d = tick;
            end
            S_PAUSE: begin
                if (halt_hit) begin
                    state_d = S_DONE;
                end else if (run_s2) begin
                    state_d  = S_RUN;
                    set_skip = 1'b1;
                end else if (step_evt) begin
                    state_d  = S_STEP;
                    set_skip = 1'b1;
                end
            end
            S_STEP: begin
                en_d    = 1'b1;
                state_d = S_PAUSE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cpu_en    <= 1'b0;
            cpu_start <= 1'b0;
            div_cnt   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            cpu_en  <= en_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && start_edge) cpu_start <= 1'b1;
            // Divider restarts from zero on every RUN entry
            if (state_q == S_RUN && state_d == S_RUN) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            else div_cnt <= '0;
        end
    end

    assign state     = state_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed and random bench for cpu_run_ctrl against a reference model
module tb_cpu_run_ctrl;
    localparam int DIV = 4;
    localparam int DBC = 4;
    localparam logic [4:0] HALT = 5'b00001;
    localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, STEP = 3'd3, DONE = 3'd4;

    logic        clk = 1'b0;
    logic        reset, start_sw, run_sw, step_btn, bp_en;
    logic [7:0]  bp_addr, i_addr;
    logic [15:0] instruction;
    logic        cpu_en, cpu_start;
    logic [2:0]  state;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulse  = 0;
    int lat;

    logic [2:0]  m_state;
    logic        m_en, m_start, m_skip, m_acc, m_acc_d;
    logic [15:0] m_cnt;
    int          m_age, m_diff;
    logic [2:0]  st_h, rn_h, sp_h;

    cpu_run_ctrl #(.DIV(DIV), .DB_CYCLES(DBC), .HALT_OP(HALT)) dut (
        .clk(clk), .reset(reset), .start_sw(start_sw), .run_sw(run_sw), .step_btn(step_btn),
        .bp_en(bp_en), .bp_addr(bp_addr), .i_addr(i_addr), .instruction(instruction),
        .cpu_en(cpu_en), .cpu_start(cpu_start), .state(state), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock of the behavioural model, from the values the DUT sampled at this edge
    task automatic model_edge();
        logic se, rs, ev, halt, bp, tick, en, setskip;
        logic [2:0] ns;
        if (reset) begin
            m_state = IDLE; m_en = 0; m_start = 0; m_cnt = 0; m_age = 0; m_skip = 0;
            m_acc = 0; m_acc_d = 0; m_diff = 0; st_h = 0; rn_h = 0; sp_h = 0;
            return;
        end
        se   = st_h[1] & ~st_h[2];
        rs   = rn_h[1];
        ev   = m_acc & ~m_acc_d;
        halt = (instruction[15:11] == HALT);
`ifdef RUN_CTRL_BP_EN
        bp = bp_en && (i_addr == bp_addr) && !m_skip;
`else
        bp = 1'b0;
`endif
        tick = (m_state == RUN) && ((m_age % DIV) == DIV - 1);
        ns = m_state; en = 0; setskip = 0;
        case (m_state)
            IDLE:  if (se) ns = rs ? RUN : PAUSE;
            RUN:   if (halt) ns = DONE; else if (bp || !rs) ns = PAUSE; else en = tick;
            PAUSE: if (halt) ns = DONE;
                   else if (rs) begin ns = RUN; setskip = 1; end
                   else if (ev) begin ns = STEP; setskip = 1; end
            STEP:  begin en = 1; ns = PAUSE; end
            default: ;
        endcase
        if (m_state == IDLE && se) m_start = 1;
        m_age = (ns == RUN && m_state == RUN) ? m_age + 1 : 0;
        m_en  = en;
        if (en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (setskip) m_skip = 1; else if (en) m_skip = 0;
        m_state = ns;
        m_acc_d = m_acc;
        if (sp_h[1] != m_acc) begin
            m_diff++;
            if (m_diff == DBC) begin m_acc = sp_h[1]; m_diff = 0; end
        end else begin
            m_diff = 0;
        end
        st_h = {st_h[1:0], start_sw};
        rn_h = {rn_h[1:0], run_sw};
        sp_h = {sp_h[1:0], step_btn};
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        if (cpu_en === 1'b1) n_pulse++;
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("cpu_en", 32'(cpu_en), 32'(m_en));
        check_eq("cpu_start", 32'(cpu_start), 32'(m_start));
        check_eq("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    endtask

    task automatic step_press(input int hold, output int first);
        first = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= hold + 12; i++) begin
            cyc();
            if (cpu_en === 1'b1 && first == 0) first = i;
            if (i == hold) step_btn = 1'b0;
        end
    endtask

    initial begin
        logic [4:0] op;
        start_sw = 0; run_sw = 0; step_btn = 0; bp_en = 0; bp_addr = 0; i_addr = 0;
        instruction = 16'h0000; reset = 1;
        repeat (3) cyc();
        reset = 0;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_en", 32'(cpu_en), 32'd0);
        check_eq("rst_start", 32'(cpu_start), 32'd0);
        check_eq("rst_cnt", 32'(cycle_cnt), 32'd0);

        run_sw = 1; start_sw = 1;
        cyc(); cyc();
        check_eq("start_early", 32'(state), 32'd0);
        cyc();
        check_eq("start_lat", 32'(state), 32'd1);
        n_pulse = 0;
        repeat (20) cyc();
        check_eq("run_cnt20", 32'(cycle_cnt), 32'd5);
        check_eq("run_pulses", 32'(n_pulse), 32'd5);

        run_sw = 0;
        repeat (3) cyc();
        check_eq("pause_lat", 32'(state), 32'd2);
        n_pulse = 0;
        repeat (8) cyc();
        check_eq("pause_nopulse", 32'(n_pulse), 32'd0);

        n_pulse = 0;
        step_press(8, lat);
        check_eq("step_lat", 32'(lat), 32'd8);
        step_press(8, lat);
        step_press(8, lat);
        check_eq("step_pulses", 32'(n_pulse), 32'd3);
        check_eq("step_cnt", 32'(cycle_cnt), 32'd8);
        n_pulse = 0;
        step_press(2, lat);
        check_eq("glitch", 32'(n_pulse), 32'd0);

`ifdef RUN_CTRL_BP_EN
        bp_en = 1; bp_addr = 8'h05; i_addr = 8'h00; run_sw = 1;
        repeat (3) cyc();
        check_eq("bp_run", 32'(state), 32'd1);
        repeat (7) cyc();
        i_addr = 8'h05;
        cyc();
        check_eq("bp_pause", 32'(state), 32'd2);
        check_eq("bp_noen", 32'(cpu_en), 32'd0);
        cyc();
        check_eq("bp_resume", 32'(state), 32'd1);
        n_pulse = 0;
        repeat (3) cyc();
        check_eq("bp_quiet", 32'(n_pulse), 32'd0);
        cyc();
        check_eq("bp_resume_pulse", 32'(cpu_en), 32'd1);
`else
        run_sw = 1;
        repeat (3) cyc();
        check_eq("run_again", 32'(state), 32'd1);
`endif
        instruction = 16'h0800;
        cyc();
        check_eq("halt_done", 32'(state), 32'd4);
        check_eq("halt_noen", 32'(cpu_en), 32'd0);
        instruction = 16'h0000; n_pulse = 0; run_sw = 0;
        repeat (4) cyc();
        start_sw = 0;
        repeat (4) cyc();
        start_sw = 1; run_sw = 1;
        step_press(8, lat);
        check_eq("done_nopulse", 32'(n_pulse), 32'd0);
        check_eq("done_hold", 32'(state), 32'd4);

        reset = 1; start_sw = 0; bp_en = 0; i_addr = 0;
        cyc();
        reset = 0;
        repeat (3) cyc();
        start_sw = 1;
        repeat (3) cyc();
        check_eq("re_run", 32'(state), 32'd1);
        repeat (3) cyc();
        reset = 1;
        cyc();
        check_eq("rm_state", 32'(state), 32'd0);
        check_eq("rm_en", 32'(cpu_en), 32'd0);
        check_eq("rm_start", 32'(cpu_start), 32'd0);
        check_eq("rm_cnt", 32'(cycle_cnt), 32'd0);

        reset = 0; start_sw = 0; run_sw = 0;
        repeat (3) cyc();
        start_sw = 1;
        repeat (3) cyc();
        check_eq("sat_pause", 32'(state), 32'd2);
        force dut.cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        cyc();
        release dut.cnt_q;
        check_eq("sat_force", 32'(cycle_cnt), 32'h0000FFFE);
        run_sw = 1; n_pulse = 0;
        repeat (20) cyc();
        check_eq("sat_hold", 32'(cycle_cnt), 32'h0000FFFF);
        check_eq("sat_pulses", 32'(n_pulse >= 3), 32'd1);
        run_sw = 0;

        reset = 1;
        cyc();
        reset = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(39) == 0) run_sw = ~run_sw;
            if ($urandom_range(49) == 0) start_sw = ~start_sw;
            if ($urandom_range(5) == 0) step_btn = ~step_btn;
            if ($urandom_range(29) == 0) bp_en = ~bp_en;
            bp_addr = 8'h05;
            i_addr  = 8'($urandom_range(7));
            op = 5'($urandom_range(31));
            if ($urandom_range(149) == 0) op = HALT;
            else if (op == HALT) op = 5'd2;
            instruction = {op, 11'($urandom)};
            reset = ($urandom_range(199) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
